// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared encodings for the branch prediction / resolution unit.
//   br_op_e    : compare mode carried on branch_op
//   bht_ctr_e  : 2-bit saturating counter states of the branch history table
//   BHT_RESET  : counter value every BHT entry takes on reset
// ----------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [1:0] {
        BR_BEQ = 2'd0,
        BR_BNE = 2'd1,
        BR_BLT = 2'd2,
        BR_BGE = 2'd3
    } br_op_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    localparam bht_ctr_e BHT_RESET = WNT;

endpackage

// File: rtl/bht_counter_table.sv
// ----------------------------------------------------------------------------
// bht_counter_table
// Table of BHT_DEPTH 2-bit saturating counters.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (all entries -> WNT)
//   i_rd_idx      : asynchronous read index
//   o_rd_ctr      : counter at i_rd_idx (value before any same-cycle update)
//   i_wr_en       : apply a saturating update at the next clk edge
//   i_wr_idx      : entry to update
//   i_wr_taken    : 1 = count up towards ST, 0 = count down towards SNT
// ----------------------------------------------------------------------------
module bht_counter_table
    import branch_pkg::*;
#(
    parameter int BHT_DEPTH = 16,
    localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    logic [1:0] r_ctr [BHT_DEPTH];
    logic [1:0] w_wr_old;

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
        logic [1:0] n;
        if (up) begin
            n = (c == ST) ? c : c + 2'd1;
        end else begin
            n = (c == SNT) ? c : c - 2'd1;
        end
        return n;
    endfunction

    // Read is a plain mux of the registers, so a same-index update in this
    // cycle is only visible after the edge (read-before-write).
    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_wr_old = r_ctr[i_wr_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_ctr[i] <= BHT_RESET;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= sat_update(w_wr_old, i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// ----------------------------------------------------------------------------
// branch_predict_unit
// Fetch-stage BHT prediction plus a one-cycle registered resolution stage
// for decode-stage branches and jumps.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   fetch_pc              : PC being fetched (BHT lookup)
//   predict_taken         : combinational prediction for fetch_pc
//   stall                 : freeze resolution registers and BHT
//   branch, jump          : resolving instruction is a branch / a jump
//   branch_op             : BEQ / BNE / BLT (signed) / BGE (signed)
//   resolve_pc            : PC of resolving instruction (BHT update index)
//   updated_pc            : resolve_pc + PC_INCREASE
//   immediate_extended    : signed branch offset
//   rdata_1, rdata_2      : signed compare operands
//   predicted_taken       : prediction made at fetch for this instruction
//   pc_src                : registered redirect request
//   redirect_pc           : registered corrected PC
//   mispredict            : registered flush request
// Optional (macro BRANCH_STATS_EN):
//   stat_branches         : saturating count of resolved branches/jumps
//   stat_mispredicts      : saturating count of mispredicts
// ----------------------------------------------------------------------------
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int BHT_DEPTH   = 16,
    parameter int PC_INCREASE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fetch_pc,
    output logic              predict_taken,
    input  logic              stall,
    input  logic              branch,
    input  logic              jump,
    input  logic [1:0]        branch_op,
    input  logic [DATA_W-1:0] resolve_pc,
    input  logic [DATA_W-1:0] updated_pc,
    input  logic [DATA_W-1:0] immediate_extended,
    input  logic [DATA_W-1:0] rdata_1,
    input  logic [DATA_W-1:0] rdata_2,
    input  logic              predicted_taken,
    output logic              pc_src,
    output logic [DATA_W-1:0] redirect_pc,
`ifdef BRANCH_STATS_EN
    output logic [DATA_W-1:0] stat_branches,
    output logic [DATA_W-1:0] stat_mispredicts,
`endif
    output logic              mispredict
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [DATA_W-1:0] PC_INC = DATA_W'(PC_INCREASE);

    logic signed [DATA_W-1:0] w_op1_p0;
    logic signed [DATA_W-1:0] w_op2_p0;
    br_op_e                   w_op_p0;
    logic                     w_cond_p0;
    logic                     w_taken_p0;
    logic [DATA_W-1:0]        w_target_p0;
    logic                     w_mis_p0;
    logic                     w_bht_upd_p0;
    logic [IDX_W-1:0]         w_fetch_idx;
    logic [IDX_W-1:0]         w_resolve_idx;
    logic [1:0]               w_fetch_ctr;
    logic                     w_unused_pc_bits;

    logic                     r_pc_src_p1;
    logic [DATA_W-1:0]        r_redirect_pc_p1;
    logic                     r_mispredict_p1;

    // ---- stage p0: fetch lookup, compare and target (combinational) ----
    assign w_fetch_idx   = fetch_pc[IDX_W+1:2];
    assign w_resolve_idx = resolve_pc[IDX_W+1:2];
    assign predict_taken = w_fetch_ctr[1];

    // PC bits outside the index field do not take part in prediction.
    assign w_unused_pc_bits = ^{fetch_pc[DATA_W-1:IDX_W+2], fetch_pc[1:0],
                                resolve_pc[DATA_W-1:IDX_W+2], resolve_pc[1:0]};

    assign w_op1_p0 = rdata_1;
    assign w_op2_p0 = rdata_2;
    assign w_op_p0  = br_op_e'(branch_op);

    always_comb begin
        w_cond_p0 = 1'b0;
        unique case (w_op_p0)
            BR_BEQ: w_cond_p0 = (w_op1_p0 == w_op2_p0);
            BR_BNE: w_cond_p0 = (w_op1_p0 != w_op2_p0);
            BR_BLT: w_cond_p0 = (w_op1_p0 <  w_op2_p0);
            BR_BGE: w_cond_p0 = (w_op1_p0 >= w_op2_p0);
            default: w_cond_p0 = 1'b0;
        endcase
    end

    assign w_taken_p0  = jump | w_cond_p0;
    // Wraps modulo 2^DATA_W; no overflow indication is wanted.
    assign w_target_p0 = updated_pc + immediate_extended - PC_INC;

    // A jump always "takes", so it mispredicts exactly when fetch guessed not-taken.
    assign w_mis_p0     = jump ? ~predicted_taken
                               : (branch & (w_taken_p0 != predicted_taken));
    // Jumps never train the table, even when branch is also raised.
    assign w_bht_upd_p0 = branch & ~jump & ~stall;

    bht_counter_table #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_fetch_idx),
        .o_rd_ctr   (w_fetch_ctr),
        .i_wr_en    (w_bht_upd_p0),
        .i_wr_idx   (w_resolve_idx),
        .i_wr_taken (w_taken_p0)
    );

    // ---- stage p1: registered resolution ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_src_p1      <= 1'b0;
            r_redirect_pc_p1 <= '0;
            r_mispredict_p1  <= 1'b0;
        end else if (!stall) begin
            if (jump) begin
                r_pc_src_p1      <= ~predicted_taken;
                r_redirect_pc_p1 <= w_target_p0;
                r_mispredict_p1  <= ~predicted_taken;
            end else if (branch) begin
                r_pc_src_p1      <= w_mis_p0;
                r_redirect_pc_p1 <= w_taken_p0 ? w_target_p0 : updated_pc;
                r_mispredict_p1  <= w_mis_p0;
            end else begin
                r_pc_src_p1      <= 1'b0;
                r_mispredict_p1  <= 1'b0;
            end
        end
    end

    assign pc_src      = r_pc_src_p1;
    assign redirect_pc = r_redirect_pc_p1;
    assign mispredict  = r_mispredict_p1;

`ifdef BRANCH_STATS_EN
    logic [DATA_W-1:0] r_stat_br_p1;
    logic [DATA_W-1:0] r_stat_mis_p1;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---- stage p1: event counters, gated exactly like resolution ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br_p1  <= '0;
            r_stat_mis_p1 <= '0;
        end else if (!stall) begin
            if (branch | jump) begin
                r_stat_br_p1 <= sat_inc(r_stat_br_p1);
            end
            if (w_mis_p0) begin
                r_stat_mis_p1 <= sat_inc(r_stat_mis_p1);
            end
        end
    end

    assign stat_branches    = r_stat_br_p1;
    assign stat_mispredicts = r_stat_mis_p1;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] fetch_pc = '0;
    logic        predict_taken;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic [1:0]  branch_op = '0;
    logic [15:0] resolve_pc = '0;
    logic [15:0] updated_pc = '0;
    logic [15:0] immediate_extended = '0;
    logic [15:0] rdata_1 = '0;
    logic [15:0] rdata_2 = '0;
    logic        predicted_taken = 1'b0;
    logic        pc_src;
    logic [15:0] redirect_pc;
    logic        mispredict;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state (plain integers, from the behavioural rules)
    int          bht [16];
    logic        exp_pc_src;
    logic [15:0] exp_redirect;
    logic        exp_mis;
    int          exp_br_cnt;
    int          exp_mis_cnt;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .DATA_W      (16),
        .BHT_DEPTH   (16),
        .PC_INCREASE (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_pc           (fetch_pc),
        .predict_taken      (predict_taken),
        .stall              (stall),
        .branch             (branch),
        .jump               (jump),
        .branch_op          (branch_op),
        .resolve_pc         (resolve_pc),
        .updated_pc         (updated_pc),
        .immediate_extended (immediate_extended),
        .rdata_1            (rdata_1),
        .rdata_2            (rdata_2),
        .predicted_taken    (predicted_taken),
        .pc_src             (pc_src),
        .redirect_pc        (redirect_pc),
`ifdef BRANCH_STATS_EN
        .stat_branches      (stat_branches),
        .stat_mispredicts   (stat_mispredicts),
`endif
        .mispredict         (mispredict)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int to_signed(input logic [15:0] v);
        return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic int idx_of(input logic [15:0] pc);
        return (int'(pc) / 4) % 16;
    endfunction

    function automatic logic exp_pred(input logic [15:0] pc);
        return bht[idx_of(pc)] >= 2;
    endfunction

    // Model of one clock edge, evaluated from the inputs present before it.
    task automatic model_step();
        int  a, b, tgt, i;
        bit  tk;
        if (rst) begin
            exp_pc_src = 1'b0; exp_mis = 1'b0; exp_redirect = 16'h0000;
            foreach (bht[k]) bht[k] = 1;
            exp_br_cnt = 0; exp_mis_cnt = 0;
        end else if (!stall) begin
            a = to_signed(rdata_1);
            b = to_signed(rdata_2);
            case (branch_op)
                2'd0: tk = (a == b);
                2'd1: tk = (a != b);
                2'd2: tk = (a < b);
                default: tk = (a >= b);
            endcase
            if (jump) tk = 1'b1;
            tgt = ((int'(updated_pc) + int'(immediate_extended) - 4) % 65536 + 65536) % 65536;
            if (jump) begin
                exp_pc_src = !predicted_taken; exp_mis = !predicted_taken;
                exp_redirect = 16'(tgt);
            end else if (branch) begin
                exp_mis = (tk != predicted_taken); exp_pc_src = exp_mis;
                exp_redirect = tk ? 16'(tgt) : updated_pc;
            end else begin
                exp_pc_src = 1'b0; exp_mis = 1'b0;
            end
            if (branch || jump) begin
                if (exp_br_cnt < 65535) exp_br_cnt++;
                if (exp_mis && exp_mis_cnt < 65535) exp_mis_cnt++;
            end
            if (branch && !jump) begin
                i = idx_of(resolve_pc);
                bht[i] = tk ? ((bht[i] == 3) ? 3 : bht[i] + 1) : ((bht[i] == 0) ? 0 : bht[i] - 1);
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic br, input logic jp, input logic [1:0] op,
                          input logic [15:0] rpc, input logic [15:0] imm,
                          input logic [15:0] r1, input logic [15:0] r2, input logic pt);
        branch = br; jump = jp; branch_op = op; resolve_pc = rpc;
        updated_pc = rpc + 16'd4; immediate_extended = imm;
        rdata_1 = r1; rdata_2 = r2; predicted_taken = pt;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b1; branch = 1'b1;
        step(); step();
        rst = 1'b0; stall = 1'b0; branch = 1'b0;
        fetch_pc = 16'h0010;
        #1;
        checks++; if (predict_taken !== 1'b0) begin failures++; $display("FAIL reset_predict: got %b want 0", predict_taken); end
        checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL reset_pc_src: got %b want 0", pc_src); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
        checks++; if (redirect_pc !== 16'h0000) begin failures++; $display("FAIL reset_redirect: got %h want 0000", redirect_pc); end
    endtask

    task automatic test_beq();
        set_br(1'b1, 1'b0, 2'd0, 16'h0020, 16'h0010, 16'd5, 16'd5, 1'b0);
        fetch_pc = 16'h0020;
        #1;
        checks++; if (predict_taken !== 1'b0) begin failures++; $display("FAIL beq_rbw_predict: got %b want 0", predict_taken); end
        step();
        checks++; if (pc_src !== 1'b1) begin failures++; $display("FAIL beq_pc_src: got %b want 1", pc_src); end
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL beq_mispredict: got %b want 1", mispredict); end
        checks++; if (redirect_pc !== 16'h0030) begin failures++; $display("FAIL beq_redirect: got %h want 0030", redirect_pc); end
        branch = 1'b0;
        #1;
        checks++; if (predict_taken !== 1'b1) begin failures++; $display("FAIL beq_trained_predict: got %b want 1", predict_taken); end
        step();
        checks++; if (pc_src !== 1'b0 || mispredict !== 1'b0) begin failures++; $display("FAIL beq_pulse_end: got %b/%b want 0/0", pc_src, mispredict); end
        checks++; if (redirect_pc !== 16'h0030) begin failures++; $display("FAIL beq_redirect_hold: got %h want 0030", redirect_pc); end
    endtask

    task automatic test_blt_bge();
        set_br(1'b1, 1'b0, 2'd2, 16'h0040, 16'h0008, 16'hFFFF, 16'h0001, 1'b1);
        step();
        checks++; if (pc_src !== 1'b0 || mispredict !== 1'b0) begin failures++; $display("FAIL blt_signed: got %b/%b want 0/0", pc_src, mispredict); end
        checks++; if (redirect_pc !== 16'h0048) begin failures++; $display("FAIL blt_redirect: got %h want 0048", redirect_pc); end
        branch_op = 2'd3;
        step();
        checks++; if (pc_src !== 1'b1 || mispredict !== 1'b1) begin failures++; $display("FAIL bge_signed: got %b/%b want 1/1", pc_src, mispredict); end
        checks++; if (redirect_pc !== 16'h0044) begin failures++; $display("FAIL bge_redirect: got %h want 0044", redirect_pc); end
        branch = 1'b0;
        step();
    endtask

    task automatic test_saturate();
        logic [15:0] want;
        fetch_pc = 16'h0008;
        for (int n = 0; n < 4; n++) begin
            set_br(1'b1, 1'b0, 2'd1, 16'h0008, 16'h0020, 16'd1, 16'd2, 1'b1);
            step();
        end
        set_br(1'b1, 1'b0, 2'd1, 16'h0008, 16'h0020, 16'd7, 16'd7, 1'b1);
        step();
        branch = 1'b0;
        #1;
        checks++; if (predict_taken !== 1'b1) begin failures++; $display("FAIL sat_after_one_nt: got %b want 1", predict_taken); end
        checks++; if (pc_src !== 1'b1) begin failures++; $display("FAIL sat_nt_redirect_req: got %b want 1", pc_src); end
        want = 16'h000C;
        checks++; if (redirect_pc !== want) begin failures++; $display("FAIL sat_nt_redirect: got %h want %h", redirect_pc, want); end
        set_br(1'b1, 1'b0, 2'd1, 16'h0008, 16'h0020, 16'd7, 16'd7, 1'b1);
        step();
        branch = 1'b0;
        #1;
        checks++; if (predict_taken !== 1'b0) begin failures++; $display("FAIL sat_after_two_nt: got %b want 0", predict_taken); end
    endtask

    task automatic test_jump_stall();
        logic        hold_src;
        logic [15:0] hold_pc;
        hold_src = pc_src; hold_pc = redirect_pc;
        fetch_pc = 16'h0000;
        set_br(1'b0, 1'b1, 2'd0, 16'h0000, 16'hFFF8, 16'd0, 16'd0, 1'b0);
        stall = 1'b1;
        step(); step();
        checks++; if (pc_src !== hold_src || redirect_pc !== hold_pc) begin failures++; $display("FAIL stall_hold: got %b/%h want %b/%h", pc_src, redirect_pc, hold_src, hold_pc); end
        stall = 1'b0;
        step();
        checks++; if (redirect_pc !== 16'hFFF8) begin failures++; $display("FAIL jump_wrap: got %h want fff8", redirect_pc); end
        checks++; if (pc_src !== 1'b1 || mispredict !== 1'b1) begin failures++; $display("FAIL jump_redirect: got %b/%b want 1/1", pc_src, mispredict); end
        // branch and jump together: jump wins, table untouched
        set_br(1'b1, 1'b1, 2'd0, 16'h0000, 16'h0010, 16'd3, 16'd4, 1'b1);
        step(); step();
        jump = 1'b0; branch = 1'b0;
        #1;
        checks++; if (predict_taken !== exp_pred(16'h0000)) begin failures++; $display("FAIL jump_no_train: got %b want %b", predict_taken, exp_pred(16'h0000)); end
        checks++; if (pc_src !== 1'b0 || redirect_pc !== 16'h0010) begin failures++; $display("FAIL jump_correct_pred: got %b/%h want 0/0010", pc_src, redirect_pc); end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            stall     = ($urandom_range(0, 7) == 0);
            branch    = $urandom_range(0, 1) == 1;
            jump      = ($urandom_range(0, 4) == 0);
            branch_op = 2'($urandom_range(0, 3));
            resolve_pc = 16'($urandom_range(0, 63));
            updated_pc = resolve_pc + 16'd4;
            immediate_extended = 16'($urandom);
            rdata_1 = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom_range(0, 3) << 14 | $urandom_range(0, 3));
            rdata_2 = ($urandom_range(0, 2) == 0) ? rdata_1 : 16'($urandom);
            predicted_taken = $urandom_range(0, 1) == 1;
            fetch_pc = ($urandom_range(0, 1) == 1) ? resolve_pc : 16'($urandom);
            #1;
            checks++; if (predict_taken !== exp_pred(fetch_pc)) begin failures++; $display("FAIL rand_predict[%0d]: got %b want %b", n, predict_taken, exp_pred(fetch_pc)); end
            step();
            checks++; if (pc_src !== exp_pc_src) begin failures++; $display("FAIL rand_pc_src[%0d]: got %b want %b", n, pc_src, exp_pc_src); end
            checks++; if (mispredict !== exp_mis) begin failures++; $display("FAIL rand_mispredict[%0d]: got %b want %b", n, mispredict, exp_mis); end
            checks++; if (redirect_pc !== exp_redirect) begin failures++; $display("FAIL rand_redirect[%0d]: got %h want %h", n, redirect_pc, exp_redirect); end
`ifdef BRANCH_STATS_EN
            checks++; if (stat_branches !== 16'(exp_br_cnt) || stat_mispredicts !== 16'(exp_mis_cnt)) begin failures++; $display("FAIL rand_stats[%0d]: got %0d/%0d want %0d/%0d", n, stat_branches, stat_mispredicts, exp_br_cnt, exp_mis_cnt); end
`endif
        end
        rst = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
        step();
    endtask

    task automatic test_stats();
`ifdef BRANCH_STATS_EN
        rst = 1'b1; step(); rst = 1'b0;
        set_br(1'b1, 1'b0, 2'd0, 16'h0010, 16'h0004, 16'd1, 16'd1, 1'b1);
        step();
        set_br(1'b1, 1'b0, 2'd1, 16'h0014, 16'h0004, 16'd1, 16'd1, 1'b1);
        step();
        set_br(1'b1, 1'b0, 2'd0, 16'h0018, 16'h0004, 16'd1, 16'd2, 1'b0);
        step();
        branch = 1'b0; step();
        checks++; if (stat_branches !== 16'd3 || stat_mispredicts !== 16'd1) begin failures++; $display("FAIL stats_count: got %0d/%0d want 3/1", stat_branches, stat_mispredicts); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (stat_branches !== 16'd0 || stat_mispredicts !== 16'd0) begin failures++; $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
`endif
    endtask

    initial begin
        test_reset();
        test_beq();
        test_blt_bge();
        test_saturate();
        test_jump_stall();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
